vending_machine_param: RTL and testbench

Parametrised successor to the fixed 1.5-dollar vending FSM. Prices, coin denominations and the credit width are all set by parameters, and credit is held in an accumulator rather than enumerated states. Adds cancel/refund, multi-unit change paid out one low-value coin per cycle, rejection of invalid or mistimed coins, and status outputs. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vending_machine_param.sv | 135 +++++++++++++
 tb/tb_vending_machine_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parametrised vending controller. Credit is held in an accumulator, vending
// returns overpayment as a train of low-coin change pulses, and cancel refunds
// whatever has been collected so far. All outputs are registered.
module vending_machine_param #(
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned PRICE    = 3,
  parameter int unsigned COIN_LO  = 1,
  parameter int unsigned COIN_HI  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                drink,
  output logic                change,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned CreditMax = (1 << CREDIT_W) - 1;

  localparam logic [CREDIT_W-1:0] PriceC  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CoinLoC = CREDIT_W'(COIN_LO);
  localparam logic [CREDIT_W-1:0] CoinHiC = CREDIT_W'(COIN_HI);
  localparam logic [CREDIT_W-1:0] OneC    = CREDIT_W'(1);

  localparam logic [1:0] CoinNone = 2'b00;
  localparam logic [1:0] CoinLo   = 2'b01;
  localparam logic [1:0] CoinHi   = 2'b10;
  localparam logic [1:0] CoinBad  = 2'b11;

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StPayout} state_e;

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [CREDIT_W-1:0]   remain_q, remain_d;
  logic                  coin_reject_q, coin_reject_d;
  logic [CREDIT_W-1:0]   coin_val;
  logic [CREDIT_W-1:0]   sum;

`ifndef SYNTHESIS
  // Flag parameter sets that would let credit + coin wrap the accumulator.
  initial begin : param_check
    if (PRICE == 0 || PRICE > CreditMax || COIN_LO != 1 || COIN_HI == 0 ||
        (PRICE - 1 + COIN_HI) > CreditMax) begin
      $error("vending_machine_param: illegal parameters PRICE=%0d COIN_LO=%0d COIN_HI=%0d CREDIT_W=%0d",
             PRICE, COIN_LO, COIN_HI, CREDIT_W);
    end
  end
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      remain_q      <= '0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      remain_q      <= remain_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Next-state, credit accumulation, change countdown and coin rejection.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    remain_d      = remain_q;
    coin_reject_d = 1'b0;

    case (coin)
      CoinLo:  coin_val = CoinLoC;
      CoinHi:  coin_val = CoinHiC;
      default: coin_val = '0;
    endcase
    sum = credit_q + coin_val;

    case (state_q)
      StIdle, StCollect: begin
        if (cancel) begin
          // A coin arriving with cancel is handed straight back.
          coin_reject_d = (coin != CoinNone);
          if (state_q == StCollect) begin
            state_d  = StPayout;
            remain_d = credit_q;
            credit_d = '0;
          end
        end else begin
          coin_reject_d = (coin == CoinBad);
          if (sum >= PriceC) begin
            state_d  = StVend;
            remain_d = sum - PriceC;
            credit_d = '0;
          end else begin
            state_d  = (sum == '0) ? StIdle : StCollect;
            credit_d = sum;
          end
        end
      end
      StVend: begin
        coin_reject_d = (coin != CoinNone);
        state_d       = (remain_q != '0) ? StPayout : StIdle;
      end
      StPayout: begin
        coin_reject_d = (coin != CoinNone);
        // Guard against zero so a corrupted count cannot wrap into a long payout.
        if (remain_q <= OneC) begin
          state_d  = StIdle;
          remain_d = '0;
        end else begin
          remain_d = remain_q - OneC;
        end
      end
      default: begin
        state_d  = StIdle;
        credit_d = '0;
        remain_d = '0;
      end
    endcase
  end

  // Moore outputs decoded from registered state.
  always_comb begin
    drink       = (state_q == StVend);
    change      = (state_q == StPayout);
    busy        = (state_q == StVend) || (state_q == StPayout);
    coin_reject = coin_reject_q;
    credit      = (state_q == StCollect) ? credit_q : '0;
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Drives two differently-configured vending controllers with the same stimulus
// and compares every output each cycle against a transaction-level model.
module tb_vending_machine_param;

  localparam int CW = 4;
  localparam int PRICE_A = 3;
  localparam int HI_A    = 2;
  localparam int PRICE_B = 5;
  localparam int HI_B    = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    coin;
  logic          cancel;

  logic          drink_a, change_a, rej_a, busy_a;
  logic [CW-1:0] credit_a;
  logic          drink_b, change_b, rej_b, busy_b;
  logic [CW-1:0] credit_b;

  int n_checks;
  int n_errors;

  // Model: credit held, change still owed, and the outputs expected right now.
  int price [2];
  int hi    [2];
  int m_credit [2];
  int m_owed   [2];
  bit m_drink  [2];
  bit m_change [2];
  bit m_rej    [2];

  vending_machine_param #(
    .CREDIT_W (CW),
    .PRICE    (PRICE_A),
    .COIN_LO  (1),
    .COIN_HI  (HI_A)
  ) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .coin        (coin),
    .cancel      (cancel),
    .drink       (drink_a),
    .change      (change_a),
    .coin_reject (rej_a),
    .busy        (busy_a),
    .credit      (credit_a)
  );

  vending_machine_param #(
    .CREDIT_W (CW),
    .PRICE    (PRICE_B),
    .COIN_LO  (1),
    .COIN_HI  (HI_B)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .coin        (coin),
    .cancel      (cancel),
    .drink       (drink_b),
    .change      (change_b),
    .coin_reject (rej_b),
    .busy        (busy_b),
    .credit      (credit_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one accepted clock edge.
  task automatic model_step(input logic [1:0] c, input logic can, input logic r);
    int v;
    int sum;
    bit busy_now;
    for (int i = 0; i < 2; i++) begin
      busy_now = m_drink[i] || m_change[i];
      if (r) begin
        m_credit[i] = 0;
        m_owed[i]   = 0;
        m_drink[i]  = 0;
        m_change[i] = 0;
        m_rej[i]    = 0;
      end else if (busy_now) begin
        m_rej[i]   = (c != 2'b00);
        m_drink[i] = 0;
        if (m_owed[i] > 0) begin
          m_change[i] = 1;
          m_owed[i]   = m_owed[i] - 1;
        end else begin
          m_change[i] = 0;
        end
      end else begin
        m_drink[i]  = 0;
        m_change[i] = 0;
        v = (c == 2'b01) ? 1 : (c == 2'b10) ? hi[i] : 0;
        if (can) begin
          m_rej[i] = (c != 2'b00);
          if (m_credit[i] > 0) begin
            m_change[i] = 1;
            m_owed[i]   = m_credit[i] - 1;
            m_credit[i] = 0;
          end
        end else begin
          m_rej[i] = (c == 2'b11);
          sum = m_credit[i] + v;
          if (sum >= price[i]) begin
            m_drink[i]  = 1;
            m_owed[i]   = sum - price[i];
            m_credit[i] = 0;
          end else begin
            m_credit[i] = sum;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("a_drink",  int'(drink_a),  int'(m_drink[0]));
    check("a_change", int'(change_a), int'(m_change[0]));
    check("a_reject", int'(rej_a),    int'(m_rej[0]));
    check("a_busy",   int'(busy_a),   int'(m_drink[0] || m_change[0]));
    check("a_credit", int'(credit_a), m_credit[0]);
    check("b_drink",  int'(drink_b),  int'(m_drink[1]));
    check("b_change", int'(change_b), int'(m_change[1]));
    check("b_reject", int'(rej_b),    int'(m_rej[1]));
    check("b_busy",   int'(busy_b),   int'(m_drink[1] || m_change[1]));
    check("b_credit", int'(credit_b), m_credit[1]);
  endtask

  // One clock: apply inputs, take the edge, check outputs 1 time unit later.
  task automatic cyc(input logic [1:0] c, input logic can, input logic r);
    coin   = c;
    cancel = can;
    rst    = r;
    @(posedge clk);
    model_step(c, can, r);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  int b_changes;

  initial begin
    n_checks = 0;
    n_errors = 0;
    price[0] = PRICE_A;
    hi[0]    = HI_A;
    price[1] = PRICE_B;
    hi[1]    = HI_B;
    for (int i = 0; i < 2; i++) begin
      m_credit[i] = 0;
      m_owed[i]   = 0;
      m_drink[i]  = 0;
      m_change[i] = 0;
      m_rej[i]    = 0;
    end
    coin   = 2'b00;
    cancel = 1'b0;
    rst    = 1'b1;

    cyc(2'b00, 1'b0, 1'b1);
    cyc(2'b00, 1'b0, 1'b1);
    cyc(2'b00, 1'b0, 1'b0);

    // Three low coins: exact payment on A.
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(2'b00, 1'b0, 1'b0);

    // Two high coins: overpayment on both configurations.
    cyc(2'b10, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(2'b00, 1'b0, 1'b0);

    // Low coin then cancel, with a high coin driven alongside cancel.
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b10, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(2'b00, 1'b0, 1'b0);

    // Coins while busy are rejected; then a coin in idle; then an invalid code.
    cyc(2'b10, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(2'b00, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0);
    cyc(2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(2'b00, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0);

    // Reset during B's second change pulse discards the rest of the payout.
    b_changes = 0;
    cyc(2'b10, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0);
    b_changes += int'(change_b);
    cyc(2'b00, 1'b0, 1'b0);
    b_changes += int'(change_b);
    check("b_change_before_rst", b_changes, 2);
    cyc(2'b00, 1'b0, 1'b1);
    check("b_all_zero_after_rst",
          int'({drink_b, change_b, rej_b, busy_b, credit_b}), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(2'b00, 1'b0, 1'b0);
      b_changes += int'(change_b);
    end
    check("b_no_change_after_rst", b_changes, 2);

    // Randomised traffic including occasional cancel and reset.
    for (int k = 0; k < 2000; k++) begin
      logic [1:0] c;
      logic       can;
      logic       r;
      c   = 2'($urandom_range(0, 3));
      can = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 99) == 0);
      cyc(c, can, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
